// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: turns one decoded stack request (PUSH/POP/CALL/RET/INT/RTI)
// into a back-to-back sequence of 16-bit stack memory operations. It gathers
// popped words into pop_data / pc_out / flags_out and strobes them in DONE.
module stack_op_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_data,
  input  logic [31:0] pc_in,
  input  logic [2:0]  flags_in,
  input  logic [15:0] mem_data,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        SPOrALUres,
  output logic [1:0]  SPOpeartion,
  output logic [15:0] RegSrc,
  output logic [15:0] pop_data,
  output logic        pop_valid,
  output logic [31:0] pc_out,
  output logic        pc_valid,
  output logic [2:0]  flags_out,
  output logic        flags_valid
);

  typedef enum logic [2:0] {S_IDLE, S_OP1, S_OP2, S_OP3, S_DONE} state_t;
  // Destination of a popped word; it travels with the read so that the
  // word arriving one cycle later lands in the right register.
  typedef enum logic [1:0] {SL_POP, SL_PCLO, SL_PCHI, SL_FLG} slot_t;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_INT  = 3'd4;
  localparam logic [2:0] OP_RTI  = 3'd5;

  state_t      r_state, w_nxt;
  logic [2:0]  r_op, r_flags;
  logic [15:0] r_data;
  logic [31:0] r_pc;

  logic        r_MemRead, r_MemWrite;
  logic [1:0]  r_SPOp;
  logic [15:0] r_RegSrc;
  slot_t       r_slot;

  logic        r_cap_vld;
  slot_t       r_cap_slot;
  logic [15:0] r_pop_data;
  logic [31:0] r_pc_out;
  logic [2:0]  r_flags_out;
  logic        r_pop_valid, r_pc_valid, r_flags_valid;

  logic        w_idle, w_accept;
  logic [2:0]  w_op, w_flags;
  logic [15:0] w_data;
  logic [31:0] w_pc;
  logic [1:0]  w_nops;
  logic        w_push, w_pop;
  logic [15:0] w_word;
  slot_t       w_slot;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle & req_valid;
  // In IDLE the request fields are used directly so OP1 can be set up on
  // the acceptance edge; afterwards the latched copies drive the sequence.
  assign w_op     = w_idle ? req_op   : r_op;
  assign w_data   = w_idle ? req_data : r_data;
  assign w_pc     = w_idle ? pc_in    : r_pc;
  assign w_flags  = w_idle ? flags_in : r_flags;

  // Number of memory operations each opcode needs; unknown opcodes need none.
  always_comb begin
    w_nops = 2'd0;
    case (w_op)
      OP_PUSH, OP_POP: w_nops = 2'd1;
      OP_CALL, OP_RET: w_nops = 2'd2;
      OP_INT,  OP_RTI: w_nops = 2'd3;
      default:         w_nops = 2'd0;
    endcase
  end

  // Next-state logic: one op per cycle, then a single DONE cycle.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_nxt = (w_nops == 2'd0) ? S_DONE : S_OP1;
      S_OP1:   w_nxt = (w_nops > 2'd1) ? S_OP2 : S_DONE;
      S_OP2:   w_nxt = (w_nops > 2'd2) ? S_OP3 : S_DONE;
      S_OP3:   w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Decode the memory operation of the state being entered, so the
  // memory-side outputs can be registered without adding latency.
  always_comb begin
    w_push = 1'b0;
    w_pop  = 1'b0;
    w_word = 16'h0000;
    w_slot = SL_POP;
    case (w_nxt)
      S_OP1: begin
        case (w_op)
          OP_PUSH:        begin w_push = 1'b1; w_word = w_data;       end
          OP_POP:         begin w_pop  = 1'b1; w_slot = SL_POP;       end
          OP_CALL, OP_INT: begin w_push = 1'b1; w_word = w_pc[31:16]; end
          OP_RET:         begin w_pop  = 1'b1; w_slot = SL_PCLO;      end
          OP_RTI:         begin w_pop  = 1'b1; w_slot = SL_FLG;       end
          default: ;
        endcase
      end
      S_OP2: begin
        case (w_op)
          OP_CALL, OP_INT: begin w_push = 1'b1; w_word = w_pc[15:0]; end
          OP_RET:         begin w_pop  = 1'b1; w_slot = SL_PCHI;     end
          OP_RTI:         begin w_pop  = 1'b1; w_slot = SL_PCLO;     end
          default: ;
        endcase
      end
      S_OP3: begin
        case (w_op)
          OP_INT: begin w_push = 1'b1; w_word = {13'b0, w_flags}; end
          OP_RTI: begin w_pop  = 1'b1; w_slot = SL_PCHI;          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // State register; reset abandons any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // Latch the request fields once, at acceptance only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= 3'd0;
      r_data  <= 16'h0000;
      r_pc    <= 32'h0;
      r_flags <= 3'd0;
    end else if (w_accept) begin
      r_op    <= req_op;
      r_data  <= req_data;
      r_pc    <= pc_in;
      r_flags <= flags_in;
    end
  end

  // Registered memory-side controls for the upcoming op cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_MemWrite <= 1'b0;
      r_MemRead  <= 1'b0;
      r_SPOp     <= 2'b00;
      r_RegSrc   <= 16'h0000;
      r_slot     <= SL_POP;
    end else begin
      r_MemWrite <= w_push;
      r_MemRead  <= w_pop;
      r_SPOp     <= w_push ? 2'b01 : (w_pop ? 2'b10 : 2'b00);
      r_RegSrc   <= w_push ? w_word : 16'h0000;
      r_slot     <= w_slot;
    end
  end

  // Capture read data the cycle after each pop into its destination slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_vld   <= 1'b0;
      r_cap_slot  <= SL_POP;
      r_pop_data  <= 16'h0000;
      r_pc_out    <= 32'h0;
      r_flags_out <= 3'd0;
    end else begin
      r_cap_vld  <= r_MemRead;
      r_cap_slot <= r_slot;
      if (r_cap_vld) begin
        case (r_cap_slot)
          SL_POP:  r_pop_data      <= mem_data;
          SL_PCLO: r_pc_out[15:0]  <= mem_data;
          SL_PCHI: r_pc_out[31:16] <= mem_data;
          SL_FLG:  r_flags_out     <= mem_data[2:0];
          default: ;
        endcase
      end
    end
  end

  // Result strobes fire for the single DONE cycle of the matching op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pop_valid   <= 1'b0;
      r_pc_valid    <= 1'b0;
      r_flags_valid <= 1'b0;
    end else begin
      r_pop_valid   <= (w_nxt == S_DONE) && (w_op == OP_POP);
      r_pc_valid    <= (w_nxt == S_DONE) && ((w_op == OP_RET) || (w_op == OP_RTI));
      r_flags_valid <= (w_nxt == S_DONE) && (w_op == OP_RTI);
    end
  end

  assign req_ready   = w_idle;
  assign MemRead     = r_MemRead;
  assign MemWrite    = r_MemWrite;
  // Stack ops always address through SP.
  assign SPOrALUres  = 1'b0;
  assign SPOpeartion = r_SPOp;
  assign RegSrc      = r_RegSrc;

  // The last pop's word arrives during DONE, so the capture cycle forwards
  // mem_data straight through; results then hold from the registers.
  assign pop_data  = (r_cap_vld && r_cap_slot == SL_POP) ? mem_data : r_pop_data;
  assign pc_out    = {(r_cap_vld && r_cap_slot == SL_PCHI) ? mem_data : r_pc_out[31:16],
                      (r_cap_vld && r_cap_slot == SL_PCLO) ? mem_data : r_pc_out[15:0]};
  assign flags_out = (r_cap_vld && r_cap_slot == SL_FLG) ? mem_data[2:0] : r_flags_out;

  assign pop_valid   = r_pop_valid;
  assign pc_valid    = r_pc_valid;
  assign flags_valid = r_flags_valid;

endmodule

// File: doc/stack_op_sequencer.md
STACK_OP_SEQUENCER -- requirements
Module: stack_op_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and rst.
REQ-002 Ports SHALL be:
clk  in  1  clock
rst  in  1  sync active-high reset
req_valid  in  1  request strobe from decode
req_ready  out  1  high when in IDLE; request accepted iff req_valid & req_ready
req_op  in  3  000 PUSH, 001 POP, 010 CALL, 011 RET, 100 INT, 101 RTI; others = no-op
req_data  in  16  PUSH operand
pc_in  in  32  return PC for CALL/INT
flags_in  in  3  CCR for INT
mem_data  in  16  memory-stage Data, valid the cycle after MemRead
MemRead  out  1  memory read
MemWrite  out  1  memory write
SPOrALUres  out  1  address select; always 0 (SP) when driving an op
SPOpeartion  out  2  01 push (pre-decrement), 10 pop (post-increment), 00 none
RegSrc  out  16  write data
pop_data  out  16  POP result
pop_valid  out  1  one-cycle strobe
pc_out  out  32  RET/RTI target
pc_valid  out  1  one-cycle strobe
flags_out  out  3  RTI restored flags
flags_valid  out  1  one-cycle strobe

Function
REQ-003 FSM states SHALL be IDLE, OP1, OP2, OP3, DONE; all memory-side outputs SHALL be registered.
REQ-004 On acceptance in cycle N, the sequence SHALL latch req_op, req_data, pc_in, flags_in; first memory op drives in cycle N+1, one op per cycle, no gaps.
REQ-005 PUSH: OP1 = push req_data. POP: OP1 = pop.
REQ-006 CALL: OP1 push pc[31:16], OP2 push pc[15:0].
REQ-007 INT: OP1 push pc[31:16], OP2 push pc[15:0], OP3 push {13'b0,flags}.
REQ-008 RET: OP1 pop -> pc[15:0], OP2 pop -> pc[31:16].
REQ-009 RTI: OP1 pop -> flags (bits 2:0), OP2 pop -> pc[15:0], OP3 pop -> pc[31:16].
REQ-010 Push cycle SHALL drive MemWrite=1, MemRead=0, SPOpeartion=01, SPOrALUres=0, RegSrc=word; pop cycle MemRead=1, MemWrite=0, SPOpeartion=10, SPOrALUres=0, RegSrc=0.
REQ-011 Outside OP states, MemRead, MemWrite, SPOrALUres, SPOpeartion, RegSrc SHALL be 0.
REQ-012 mem_data SHALL be captured in the cycle after each pop cycle into the slot named in REQ-008/009.
REQ-013 DONE SHALL be entered the cycle after the last op, lasting one cycle; in it pop_valid (POP), pc_valid (RET, RTI), flags_valid (RTI additionally) pulse for exactly that cycle; for push-only ops DONE pulses no strobe.
REQ-014 DONE -> IDLE unconditionally; req_ready=1 only in IDLE, so back-to-back requests are spaced by at least one IDLE cycle.
REQ-015 req_valid while req_ready=0 SHALL be ignored, with no latching and no effect.
REQ-016 An undefined req_op, if accepted, SHALL go IDLE -> DONE with no memory op and no strobe.
REQ-017 pop_data, pc_out, flags_out SHALL hold their last captured value until overwritten.

Reset
REQ-018 rst sampled high SHALL force IDLE and zero all outputs except req_ready=1, overriding any in-progress sequence, including mid-CALL/INT. No further memory op is issued and no strobe fires.
REQ-019 rst and req_valid in the same cycle: reset wins; the request is dropped.

Verification
REQ-020 PUSH req_data=0x0010 at N -> cycle N+1: MemWrite=1, SPOpeartion=01, RegSrc=0x0010; N+2 DONE, no strobe; N+3 req_ready=1.
REQ-021 CALL pc_in=0x00AB_1234, then RET with model memory -> pushes 0x00AB then 0x1234; RET pops 0x1234, 0x00AB; pc_out=0x00AB1234 with pc_valid single pulse.
REQ-022 INT pc_in=0x0000_0042, flags=3'b101, then RTI -> three pushes 0x0000, 0x0042, 0x0005; RTI yields flags_out=101, pc_out=0x00000042, flags_valid and pc_valid same cycle.
REQ-023 req_valid held high during CALL busy cycles with op=POP -> ignored; exactly 2 memory ops issued; POP accepted only once back in IDLE.
REQ-024 rst asserted in OP2 of INT -> next cycle all memory outputs 0, req_ready=1; no third push; no strobe.
REQ-025 req_op=111 accepted -> no MemRead/MemWrite ever; DONE one cycle; all strobes remain 0.
